// File: rtl/ahb_bus_adapter_pkg.sv
// Shared AHB encodings, FSM state constants and transfer decode helpers
// for the AHB-to-generic-bus adapter.
package ahb_bus_adapter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_ERR1   = 2'd2;
    localparam state_t ST_ERR2   = 2'd3;

    // Byte-lane enables for a transfer of the given size at the given low address bits.
    function automatic logic [3:0] strobe_decode(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] s;
        s = '0;
        case (size)
            HSIZE_BYTE: s = 4'b0001 << a;
            HSIZE_HALF: s = a[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: s = 4'b1111;
            default:    s = '0;
        endcase
        return s;
    endfunction

    // Beat count for fixed-length bursts; INCR has no defined length and reports 0.
    function automatic logic [7:0] burst_len_decode(input logic [2:0] b);
        logic [7:0] n;
        n = '0;
        case (b)
            HBURST_SINGLE:                n = 8'd1;
            HBURST_WRAP4,  HBURST_INCR4:  n = 8'd4;
            HBURST_WRAP8,  HBURST_INCR8:  n = 8'd8;
            HBURST_WRAP16, HBURST_INCR16: n = 8'd16;
            default:                      n = 8'd0;
        endcase
        return n;
    endfunction

    // 2'b01 marks a wrapping burst, 2'b00 an incrementing (or single) one.
    function automatic logic [1:0] burst_type_decode(input logic [2:0] b);
        return (b == HBURST_WRAP4 || b == HBURST_WRAP8 || b == HBURST_WRAP16) ? 2'b01 : 2'b00;
    endfunction

    // Oversized or misaligned transfers are answered with an ERROR response.
    function automatic logic is_illegal(input logic [2:0] size, input logic [1:0] a);
        return (size > HSIZE_WORD) ||
               (size == HSIZE_HALF && a[0]) ||
               (size == HSIZE_WORD && a != 2'b00);
    endfunction

endpackage

// File: rtl/ahb_bus_adapter.sv
// AHB subordinate that turns accepted address phases into single-cycle
// (stallable) accesses on a simple generic bus, with two-cycle ERROR
// responses for illegal transfers and peripheral errors.
module ahb_bus_adapter
    import ahb_bus_adapter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  wen,
    output logic                  ren,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            strobe,
    output logic                  is_burst,
    output logic [1:0]            burst_type,
    output logic [7:0]            burst_length,
    output logic                  secure_transfer,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  error,
    input  logic                  request_stall
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [3:0]            strobe_q;
    logic                  is_burst_q;
    logic [1:0]            burst_type_q;
    logic [7:0]            burst_len_q;

    logic accept;
    logic can_accept;
    logic legal;
    logic access_done;

    assign accept      = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign legal       = !is_illegal(HSIZE, HADDR[1:0]);
    assign access_done = (state_q == ST_ACCESS) && !request_stall && !error;
    // A new address phase is only taken on an edge where this subordinate is itself ready.
    assign can_accept  = (state_q == ST_IDLE) || (state_q == ST_ERR2) || access_done;

    // Next-state selection for the transfer FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) state_d = legal ? ST_ACCESS : ST_ERR1;
                else        state_d = ST_IDLE;
            end
            ST_ACCESS: begin
                if (request_stall)  state_d = ST_ACCESS;
                else if (error)     state_d = ST_ERR1;
                else if (accept)    state_d = legal ? ST_ACCESS : ST_ERR1;
                else                state_d = ST_IDLE;
            end
            ST_ERR1:  state_d = ST_ERR2;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM state register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Capture address-phase controls and burst hints for legal accepted transfers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q       <= '0;
            write_q      <= 1'b0;
            strobe_q     <= '0;
            is_burst_q   <= 1'b0;
            burst_type_q <= '0;
            burst_len_q  <= '0;
        end else if (accept && can_accept && legal) begin
            addr_q       <= HADDR;
            write_q      <= HWRITE;
            strobe_q     <= strobe_decode(HSIZE, HADDR[1:0]);
            is_burst_q   <= (HBURST != HBURST_SINGLE);
            burst_type_q <= burst_type_decode(HBURST);
            burst_len_q  <= burst_len_decode(HBURST);
        end
    end

    // AHB response signals decoded from the current state.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            ST_ACCESS: HREADYOUT = access_done;
            ST_ERR1:   begin HREADYOUT = 1'b0; HRESP = 1'b1; end
            ST_ERR2:   begin HREADYOUT = 1'b1; HRESP = 1'b1; end
            default:   begin HREADYOUT = 1'b1; HRESP = 1'b0; end
        endcase
    end

    assign wen             = (state_q == ST_ACCESS) &&  write_q;
    assign ren             = (state_q == ST_ACCESS) && !write_q;
    assign HRDATA          = ren ? rdata : '0;
    assign addr            = addr_q;
    assign wdata           = HWDATA;
    assign strobe          = strobe_q;
    assign is_burst        = is_burst_q;
    assign burst_type      = burst_type_q;
    assign burst_length    = burst_len_q;
    assign secure_transfer = 1'b0;

endmodule

// File: tb/tb_ahb_bus_adapter.sv
// Directed self-checking bench for ahb_bus_adapter.
module tb_ahb_bus_adapter;

    logic        CLK, nRST;
    logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic        wen, ren, is_burst, secure_transfer;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  strobe;
    logic [1:0]  burst_type;
    logic [7:0]  burst_length;
    logic        error, request_stall;

    int n_checks = 0;
    int n_errors = 0;
    int ren_cnt, low_cnt;

    ahb_bus_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .nRST(nRST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .wen(wen), .ren(ren), .addr(addr), .wdata(wdata), .strobe(strobe),
        .is_burst(is_burst), .burst_type(burst_type), .burst_length(burst_length),
        .secure_transfer(secure_transfer), .rdata(rdata), .error(error),
        .request_stall(request_stall)
    );

    // Single-subordinate system: bus-wide ready is this subordinate's ready.
    assign HREADY = HREADYOUT;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic addr_phase(input logic [1:0] trans, input logic [31:0] a,
                              input logic [2:0] size, input logic [2:0] burst, input logic wr);
        HSEL = 1'b1; HTRANS = trans; HADDR = a; HSIZE = size; HBURST = burst; HWRITE = wr;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'd0; HADDR = '0; HSIZE = 3'd0; HBURST = 3'd0; HWRITE = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
        chk({pfx, "_hresp"},     32'(HRESP), 32'd0);
        chk({pfx, "_hrdata"},    HRDATA, 32'd0);
        chk({pfx, "_wen"},       32'(wen), 32'd0);
        chk({pfx, "_ren"},       32'(ren), 32'd0);
        chk({pfx, "_addr"},      addr, 32'd0);
        chk({pfx, "_strobe"},    32'(strobe), 32'd0);
        chk({pfx, "_is_burst"},  32'(is_burst), 32'd0);
        chk({pfx, "_btype"},     32'(burst_type), 32'd0);
        chk({pfx, "_blen"},      32'(burst_length), 32'd0);
        chk({pfx, "_secure"},    32'(secure_transfer), 32'd0);
    endtask

    initial begin
        nRST = 1'b0; bus_idle(); HWDATA = '0; rdata = '0; error = 1'b0; request_stall = 1'b0;
        #1;
        chk_reset_vals("reset");
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;

        // Word write 0xDEADBEEF to 0x10, no stall
        @(negedge CLK);
        addr_phase(2'd2, 32'h10, 3'd2, 3'd0, 1'b1);
        #1 chk("w_idle_ready", 32'(HREADYOUT), 32'd1);
        @(negedge CLK);
        bus_idle(); HWDATA = 32'hDEADBEEF;
        #1;
        chk("w_wen", 32'(wen), 32'd1);
        chk("w_ren", 32'(ren), 32'd0);
        chk("w_addr", addr, 32'h10);
        chk("w_strobe", 32'(strobe), 32'hF);
        chk("w_wdata", wdata, 32'hDEADBEEF);
        chk("w_ready", 32'(HREADYOUT), 32'd1);
        chk("w_resp", 32'(HRESP), 32'd0);
        chk("w_blen", 32'(burst_length), 32'd1);
        chk("w_isburst", 32'(is_burst), 32'd0);
        @(negedge CLK); #1;
        chk("w_wen_drop", 32'(wen), 32'd0);

        // Byte read at 0x13, three stall cycles
        @(negedge CLK);
        addr_phase(2'd2, 32'h13, 3'd0, 3'd0, 1'b0);
        ren_cnt = 0; low_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            bus_idle(); rdata = 32'hAB000000; request_stall = (i < 3);
            #1;
            if (ren) ren_cnt++;
            if (!HREADYOUT) low_cnt++;
            if (i == 0) chk("r_strobe", 32'(strobe), 32'h8);
            if (i == 3) chk("r_hrdata", HRDATA, 32'hAB000000);
        end
        chk("r_ren_cycles", 32'(ren_cnt), 32'd4);
        chk("r_wait_cycles", 32'(low_cnt), 32'd3);
        @(negedge CLK);
        request_stall = 1'b0;
        #1;
        chk("r_ren_drop", 32'(ren), 32'd0);
        chk("r_hrdata_idle", HRDATA, 32'd0);

        // Misaligned word at 0x02
        @(negedge CLK);
        addr_phase(2'd2, 32'h02, 3'd2, 3'd0, 1'b0);
        @(negedge CLK);
        bus_idle();
        #1;
        chk("mis_noacc", 32'({ren, wen}), 32'd0);
        chk("mis_e1_ready", 32'(HREADYOUT), 32'd0);
        chk("mis_e1_resp", 32'(HRESP), 32'd1);
        @(negedge CLK); #1;
        chk("mis_e2_ready", 32'(HREADYOUT), 32'd1);
        chk("mis_e2_resp", 32'(HRESP), 32'd1);
        chk("mis_e2_noacc", 32'({ren, wen}), 32'd0);
        @(negedge CLK); #1;
        chk("mis_idle_resp", 32'(HRESP), 32'd0);

        // Peripheral error on a write
        @(negedge CLK);
        addr_phase(2'd2, 32'h40, 3'd2, 3'd0, 1'b1);
        @(negedge CLK);
        bus_idle(); error = 1'b1;
        #1;
        chk("pe_wen", 32'(wen), 32'd1);
        chk("pe_acc_ready", 32'(HREADYOUT), 32'd0);
        @(negedge CLK);
        error = 1'b0;
        #1;
        chk("pe_e1", 32'({HREADYOUT, HRESP, wen}), 32'b010);
        @(negedge CLK); #1;
        chk("pe_e2", 32'({HREADYOUT, HRESP}), 32'b11);
        @(negedge CLK); #1;
        chk("pe_idle", 32'({HREADYOUT, HRESP, wen}), 32'b100);

        // Back-to-back NONSEQ write 0x20 then SEQ read 0x24, INCR4
        @(negedge CLK);
        addr_phase(2'd2, 32'h20, 3'd2, 3'd3, 1'b1);
        @(negedge CLK);
        addr_phase(2'd3, 32'h24, 3'd2, 3'd3, 1'b0);
        HWDATA = 32'h11112222; rdata = 32'h5555AAAA;
        #1;
        chk("bb_wen", 32'(wen), 32'd1);
        chk("bb_waddr", addr, 32'h20);
        chk("bb_hints", 32'({is_burst, burst_type, burst_length}), {21'd0, 1'b1, 2'b00, 8'd4});
        @(negedge CLK);
        bus_idle();
        #1;
        chk("bb_ren", 32'({ren, wen}), 32'b10);
        chk("bb_raddr", addr, 32'h24);
        chk("bb_hrdata", HRDATA, 32'h5555AAAA);
        @(negedge CLK); #1;
        chk("bb_end", 32'({ren, wen}), 32'd0);

        // Half read at 0x06 in a WRAP8 burst
        @(negedge CLK);
        addr_phase(2'd2, 32'h06, 3'd1, 3'd4, 1'b0);
        @(negedge CLK);
        bus_idle();
        #1;
        chk("h_strobe", 32'(strobe), 32'hC);
        chk("h_hints", 32'({is_burst, burst_type, burst_length}), {21'd0, 1'b1, 2'b01, 8'd8});
        chk("h_ren", 32'(ren), 32'd1);

        // BUSY while selected: no access, zero-wait OKAY
        @(negedge CLK);
        addr_phase(2'd1, 32'h80, 3'd2, 3'd1, 1'b1);
        @(negedge CLK);
        bus_idle();
        #1;
        chk("busy_noacc", 32'({ren, wen}), 32'd0);
        chk("busy_okay", 32'({HREADYOUT, HRESP}), 32'b10);

        // HSIZE=3 at an aligned address is still illegal
        @(negedge CLK);
        addr_phase(2'd2, 32'h00, 3'd3, 3'd0, 1'b1);
        @(negedge CLK);
        bus_idle();
        #1;
        chk("sz3_e1", 32'({HREADYOUT, HRESP, wen}), 32'b010);
        @(negedge CLK); @(negedge CLK);

        // Reset pulse while a read is stalled
        @(negedge CLK);
        addr_phase(2'd2, 32'h30, 3'd0, 3'd1, 1'b0);
        @(negedge CLK);
        bus_idle(); request_stall = 1'b1; rdata = 32'h12345678;
        #1;
        chk("rst_pre_ren", 32'(ren), 32'd1);
        #1 nRST = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge CLK);
        nRST = 1'b1; request_stall = 1'b0;
        #1;
        chk("post_rst_ren", 32'(ren), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
